scpad_req_arbiter: RTL

Per-scratchpad request arbiter at the head of the scratchpad body. Merges backend (DRAM fill/drain) and frontend (vector core) requests into one registered request stream toward the write/read crossbars. Backend has fixed priority; a bounded-starvation counter guarantees frontend progress. Honours the body's separate write and read backpressure and exposes grant counters for performance analysis.

---
 rtl/scpad_pkg.sv | 21 ++
 rtl/scpad_arb_slot.sv | 48 ++++
 rtl/scpad_req_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/scpad_pkg.sv
// Shared types and defaults for the scratchpad body request path.
package scpad_pkg;

  localparam int SCPAD_ADDR_W     = 16;
  localparam int SCPAD_DATA_W     = 128;
  localparam int SCPAD_STARVE_MAX = 8;

  // Request source as recorded in the output slot.
  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } arb_src_e;

  // One scratchpad request at the default body widths.
  typedef struct packed {
    logic                    write;
    logic [SCPAD_ADDR_W-1:0] addr;
    logic [SCPAD_DATA_W-1:0] wdata;
  } scpad_req_t;

endpackage

// File: rtl/scpad_arb_slot.sv
// One-entry registered output slot: load on grant, hold while the body
// stalls the held request type, empty when it drains with nothing new.
module scpad_arb_slot
  import scpad_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              load_write,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  input  arb_src_e          load_src,
  input  logic              w_stall,
  input  logic              r_stall,
  output logic              out_valid,
  output logic              out_write,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output arb_src_e          out_src,
  output logic              free
);

  // The stall that matters is the one for the request already held.
  assign free = !(out_valid && (out_write ? w_stall : r_stall));

  // Slot register: clear, load a granted request, or drop a drained one.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_write <= 1'b0;
      out_addr  <= '0;
      out_wdata <= '0;
      out_src   <= SRC_FE;
    end else if (load) begin
      out_valid <= 1'b1;
      out_write <= load_write;
      out_addr  <= load_addr;
      out_wdata <= load_wdata;
      out_src   <= load_src;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/scpad_req_arbiter.sv
// Merges backend and frontend scratchpad requests into one registered
// stream. Backend has fixed priority; the frontend is forced through after
// STARVE_MAX consecutive losses.
module scpad_req_arbiter
  import scpad_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 128,
  parameter int STARVE_MAX = SCPAD_STARVE_MAX,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              be_valid,
  input  logic              be_write,
  input  logic [ADDR_W-1:0] be_addr,
  input  logic [DATA_W-1:0] be_wdata,
  output logic              be_ready,
  input  logic              fe_valid,
  input  logic              fe_write,
  input  logic [ADDR_W-1:0] fe_addr,
  input  logic [DATA_W-1:0] fe_wdata,
  output logic              fe_ready,
  input  logic              w_stall,
  input  logic              r_stall,
  output logic              out_valid,
  output logic              out_write,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_src,
  output logic [CNT_W-1:0]  be_grants,
  output logic [CNT_W-1:0]  fe_grants
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic          slot_free;
  logic          fe_force;
  logic          be_win;
  logic          fe_win;
  logic [SW-1:0] starve_cnt;
  arb_src_e      slot_src;

  assign fe_force = be_valid && fe_valid && (starve_cnt == STARVE_LIM);
  assign be_win   = be_valid && !fe_force;
  assign fe_win   = fe_valid && !be_win;

  // Readies are gated by n_rst so nothing is accepted during reset.
  assign be_ready = n_rst && slot_free && be_win;
  assign fe_ready = n_rst && slot_free && fe_win;
  assign out_src  = slot_src;

  scpad_arb_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (be_ready || fe_ready),
    .load_write (be_ready ? be_write : fe_write),
    .load_addr  (be_ready ? be_addr  : fe_addr),
    .load_wdata (be_ready ? be_wdata : fe_wdata),
    .load_src   (be_ready ? SRC_BE   : SRC_FE),
    .w_stall    (w_stall),
    .r_stall    (r_stall),
    .out_valid  (out_valid),
    .out_write  (out_write),
    .out_addr   (out_addr),
    .out_wdata  (out_wdata),
    .out_src    (slot_src),
    .free       (slot_free)
  );

  // Count consecutive frontend losses; a stall cycle leaves the count alone.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      starve_cnt <= '0;
    end else if (fe_ready || !fe_valid) begin
      starve_cnt <= '0;
    end else if (be_ready && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Free-running grant counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      be_grants <= '0;
      fe_grants <= '0;
    end else begin
      if (be_ready) be_grants <= be_grants + CNT_W'(1);
      if (fe_ready) fe_grants <= fe_grants + CNT_W'(1);
    end
  end

endmodule
